pio_pin_ctrl: RTL and testbench
===============================

# pio_pin_ctrl

Parametrised pin-mapping stage for a PIO state machine, replacing the combinational latch-based mapper. Holds registered per-pin output-value and output-enable state, and accepts OUT, SET and side-set writes with per-pin priority. Maps base/count windows modulo `NPINS`, so windows wrap around the top pin. Samples pad inputs through a synchronizer and returns them rotated to `in_base`. Sits between the state-machine execute unit and the top-level tristate pad wrapper.

## Interface
- `NPINS`, 32: number of GPIOs; 1..32.
- `SYNC_STAGES`, 2: input synchronizer depth; ≥2.
- `clock` input 1: single clock.
- `reset` input 1: asynchronous, active-high.
- `cfg_in_base` input 5: first pin of the IN window.
- `cfg_out_base`, `cfg_set_base`, `cfg_side_base` input 5 each: window bases.
- `cfg_out_count` input 6: OUT window width, 0..32.
- `cfg_set_count` input 3: SET window width, 0..5.
- `cfg_side_count` input 3: side-set window width, 0..5.
- `out_data` input 32, `out_en` input 1, `out_dir` input 1: OUT write; `out_dir`=1 targets pindirs instead of pins.
- `set_data` input 5, `set_en` input 1, `set_dir` input 1: SET write.
- `side_data` input 5, `side_en` input 1, `side_dir` input 1: side-set write.
- `pad_in` input NPINS: raw pad inputs, asynchronous.
- `pad_out` output NPINS: registered pin output values.
- `pad_oe` output NPINS: registered output enables; 1 = drive.
- `in_data` output 32: synchronized pins, rotated so bit 0 = pin `cfg_in_base`.

## Operation
- Window mapping: bit k of a write (k < count) targets pin `(base + k) mod NPINS`. Counts above `NPINS` are clamped to `NPINS`. Count 0 means no pins are affected.
- Two state registers, `pins_q` and `dirs_q`, each NPINS bits. Each write goes to `dirs_q` if its `*_dir` is 1, otherwise to `pins_q`.
- Per-pin priority within one cycle: side-set > SET > OUT. Pins outside every active window hold their value.
- Different writes may hit different registers in the same cycle. Example: side-set to pindirs and OUT to pins both take effect.
- `pad_out` = `pins_q`; `pad_oe` = `dirs_q`. The value register drives the pad even while OE=0, so the value is ready when the direction flips.
- Input path: `pad_in` → `SYNC_STAGES` flops → `sync_q`.
- `in_data` is `sync_q` rotated right by `cfg_in_base`, modulo NPINS, zero-extended to 32 bits. The IN instruction applies its own bit count downstream; this block applies no mask.
- Config changes take effect on the next write. Already-held state is never remapped.

## Timing
- Reset: `pins_q`, `dirs_q` and all synchronizer flops are 0. `pad_out`=0, `pad_oe`=0, `in_data`=0.
- Write latency: an enable high at edge N updates `pad_out`/`pad_oe` after edge N; the new value is visible in cycle N+1.
- Input latency: a pad change stable before edge N appears on `in_data` after edge N+SYNC_STAGES-1. `in_data` is combinational from `sync_q` and `cfg_in_base`.
- Reset asserted mid-operation clears all state immediately, regardless of enables. The first write after release lands on the first edge with `reset` low.
- Wrap-around boundary, NPINS=32, base=30, count=4: pins 30, 31, 0, 1.

## Configuration
- `PIO_PIN_SYNC_EN`, defined: synchronizer present, behaviour as above.
- Undefined: `sync_q` is a single register stage (latency 1, no metastability protection), for simulation and FPGA bring-up only. `SYNC_STAGES` is ignored.

## Structure
- Shared package `pio_pkg`:
  - `PIO_MAX_PINS`=32
  - pin-index and count widths
  - write-source enum (OUT, SET, SIDE) with its priority order
  - a `rotl`/`rotr`-by-base function shared with the shifter.
- One sub-module: `pio_window_mask`, combinational. Takes base, count and data; returns an NPINS-bit wrapped mask and aligned data. Instantiated three times.
- Tristate resolution stays in the top-level pad wrapper, not here.

## Test plan
- Reset: assert `reset` asynchronously with pins driven → `pad_out`=0, `pad_oe`=0 before the next edge; `in_data`=0.
- OUT wrap: out_base=30, count=4, `out_data`=0xF, `out_dir`=0 → `pad_out`=0xC0000003 one cycle later; other bits unchanged.
- Priority: same cycle, OUT base=0 count=8 data=0x00; SET base=0 count=4 data=0xF; side base=2 count=2 data=0x0 → `pad_out[7:0]`=0x03.
- Split targets: side-set pindirs base=4 count=1 data=1 plus OUT pins base=4 count=1 data=1 → `pad_oe[4]`=1 and `pad_out[4]`=1 after one edge.
- Input: `pad_in`=0x0000_0100, in_base=8 → `in_data`=0x1 after 2 edges with `PIO_PIN_SYNC_EN`, after 1 edge without it.
- Count edges: count=0 → no change. cfg_out_count=32 with NPINS=16 → clamped, all 16 pins written, no X.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared PIO pin-mapping definitions: widths, write-source priority and the
// modulo-NPINS rotate helpers used by the window masks and the IN shifter.
package pio_pkg;
  localparam int PIO_MAX_PINS = 32;
  localparam int PIN_W        = 5;
  localparam int CNT_W        = 6;
  localparam int NUM_SRC      = 3;

  // Ascending priority: a higher-numbered source overrides lower ones on a shared pin.
  typedef enum logic [1:0] {
    SRC_OUT  = 2'd0,
    SRC_SET  = 2'd1,
    SRC_SIDE = 2'd2
  } wrSrc_e;

  typedef struct packed {
    logic [PIN_W-1:0]        base;
    logic [CNT_W-1:0]        count;
    logic [PIO_MAX_PINS-1:0] data;
    logic                    en;
    logic                    dir;
  } wrReq_t;

  // Rotate the low n bits of v left by sh (mod n); bits at and above n are zero.
  function automatic logic [PIO_MAX_PINS-1:0] rotl(input logic [PIO_MAX_PINS-1:0] v,
                                                    input logic [PIN_W-1:0] sh,
                                                    input int n);
    logic [PIO_MAX_PINS-1:0] r;
    logic [PIN_W-1:0]        j;
    int                      s;
    r = '0;
    s = int'(sh) % n;
    for (int i = 0; i < PIO_MAX_PINS; i++) begin
      if (i < n) begin
        j    = PIN_W'((i + s) % n);
        r[j] = v[i];
      end
    end
    return r;
  endfunction

  // Rotate the low n bits of v right by sh (mod n); bits at and above n are zero.
  function automatic logic [PIO_MAX_PINS-1:0] rotr(input logic [PIO_MAX_PINS-1:0] v,
                                                    input logic [PIN_W-1:0] sh,
                                                    input int n);
    logic [PIO_MAX_PINS-1:0] r;
    logic [PIN_W-1:0]        j;
    int                      s;
    r = '0;
    s = int'(sh) % n;
    for (int i = 0; i < PIO_MAX_PINS; i++) begin
      if (i < n) begin
        j    = PIN_W'((i + s) % n);
        r[i] = v[j];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/pio_pin_ctrl_if.sv
// Execute-unit side of the pin controller: window config, the three write
// ports and the rotated IN data returned to the shifter.
interface pio_pin_ctrl_if;
  import pio_pkg::*;

  logic [PIN_W-1:0]        cfg_in_base;
  logic [PIN_W-1:0]        cfg_out_base;
  logic [PIN_W-1:0]        cfg_set_base;
  logic [PIN_W-1:0]        cfg_side_base;
  logic [CNT_W-1:0]        cfg_out_count;
  logic [2:0]              cfg_set_count;
  logic [2:0]              cfg_side_count;
  logic [PIO_MAX_PINS-1:0] out_data;
  logic                    out_en;
  logic                    out_dir;
  logic [4:0]              set_data;
  logic                    set_en;
  logic                    set_dir;
  logic [4:0]              side_data;
  logic                    side_en;
  logic                    side_dir;
  logic [PIO_MAX_PINS-1:0] in_data;

  modport master (
    output cfg_in_base, cfg_out_base, cfg_set_base, cfg_side_base,
    output cfg_out_count, cfg_set_count, cfg_side_count,
    output out_data, out_en, out_dir,
    output set_data, set_en, set_dir,
    output side_data, side_en, side_dir,
    input  in_data
  );

  modport slave (
    input  cfg_in_base, cfg_out_base, cfg_set_base, cfg_side_base,
    input  cfg_out_count, cfg_set_count, cfg_side_count,
    input  out_data, out_en, out_dir,
    input  set_data, set_en, set_dir,
    input  side_data, side_en, side_dir,
    output in_data
  );
endinterface

// File: rtl/pio_window_mask.sv
// Combinational base/count window: NPINS-bit pin mask wrapping modulo NPINS,
// plus write data aligned onto those pins (zero outside the window).
module pio_window_mask
  import pio_pkg::*;
#(
  parameter int NPINS = 32
) (
  input  logic [PIN_W-1:0]        base,
  input  logic [CNT_W-1:0]        count,
  input  logic [PIO_MAX_PINS-1:0] data,
  output logic [NPINS-1:0]        mask,
  output logic [NPINS-1:0]        val
);
  logic [PIO_MAX_PINS-1:0] therm;
  logic [PIO_MAX_PINS-1:0] maskW;
  logic [PIO_MAX_PINS-1:0] valW;

  // Thermometer of min(count, NPINS) ones, so oversized counts clamp cleanly.
  always_comb begin
    therm = '0;
    for (int k = 0; k < PIO_MAX_PINS; k++) begin
      if (k < NPINS && k < int'(count)) therm[k] = 1'b1;
    end
    maskW = rotl(therm, base, NPINS);
    valW  = rotl(data & therm, base, NPINS);
  end

  assign mask = maskW[NPINS-1:0];
  assign val  = valW[NPINS-1:0];
endmodule

// File: rtl/pio_pin_ctrl.sv
// PIO pin-mapping stage: registered pins/pindirs with side > SET > OUT priority
// and a synchronized, rotated IN path. Define PIO_PIN_SYNC_EN for the
// SYNC_STAGES-deep synchronizer; otherwise a single bring-up register is used.
module pio_pin_ctrl
  import pio_pkg::*;
#(
  parameter int NPINS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  pio_pin_ctrl_if.slave    bus,
  input  logic [NPINS-1:0] pad_in,
  output logic [NPINS-1:0] pad_out,
  output logic [NPINS-1:0] pad_oe
);
`ifdef PIO_PIN_SYNC_EN
  localparam int STG = SYNC_STAGES;
`else
  // Depth parameter has no effect in the bring-up build.
  localparam int STG = (SYNC_STAGES > 0) ? 1 : 1;
`endif

  wrReq_t [NUM_SRC-1:0]            req;
  logic   [NUM_SRC-1:0][NPINS-1:0] winMask;
  logic   [NUM_SRC-1:0][NPINS-1:0] winVal;
  logic   [NPINS-1:0]              pinsQ, pinsD;
  logic   [NPINS-1:0]              dirsQ, dirsD;
  logic   [STG-1:0][NPINS-1:0]     syncPipe;

  always_comb begin
    req[SRC_OUT]  = '{base: bus.cfg_out_base, count: bus.cfg_out_count,
                      data: bus.out_data, en: bus.out_en, dir: bus.out_dir};
    req[SRC_SET]  = '{base: bus.cfg_set_base, count: CNT_W'(bus.cfg_set_count),
                      data: PIO_MAX_PINS'(bus.set_data), en: bus.set_en, dir: bus.set_dir};
    req[SRC_SIDE] = '{base: bus.cfg_side_base, count: CNT_W'(bus.cfg_side_count),
                      data: PIO_MAX_PINS'(bus.side_data), en: bus.side_en, dir: bus.side_dir};
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_win
    pio_window_mask #(.NPINS(NPINS)) u_win (
      .base  (req[s].base),
      .count (req[s].count),
      .data  (req[s].data),
      .mask  (winMask[s]),
      .val   (winVal[s])
    );
  end

  // Apply sources lowest priority first so higher ones win per pin.
  always_comb begin
    pinsD = pinsQ;
    dirsD = dirsQ;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (req[s].en) begin
        if (req[s].dir) dirsD = (dirsD & ~winMask[s]) | (winVal[s] & winMask[s]);
        else            pinsD = (pinsD & ~winMask[s]) | (winVal[s] & winMask[s]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pinsQ <= '0;
      dirsQ <= '0;
    end else begin
      pinsQ <= pinsD;
      dirsQ <= dirsD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncPipe <= '0;
    end else begin
      syncPipe[0] <= pad_in;
      for (int i = 1; i < STG; i++) syncPipe[i] <= syncPipe[i-1];
    end
  end

  assign pad_out     = pinsQ;
  assign pad_oe      = dirsQ;
  assign bus.in_data = rotr(PIO_MAX_PINS'(syncPipe[STG-1]), bus.cfg_in_base, NPINS);
endmodule

// File: tb/tb_pio_pin_ctrl.sv
// Directed bench for pio_pin_ctrl: reset, wrapped windows, priority, split
// pins/pindirs targets, input latency/rotation and count clamping at NPINS=16.
module tb_pio_pin_ctrl;
`ifdef PIO_PIN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pad_in;
  logic [31:0] pad_out, pad_oe;
  logic [15:0] pad_in16;
  logic [15:0] pad_out16, pad_oe16;
  int          nCmp = 0;
  int          nErr = 0;

  pio_pin_ctrl_if bus();
  pio_pin_ctrl_if bus16();

  pio_pin_ctrl #(.NPINS(32), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe)
  );

  pio_pin_ctrl #(.NPINS(16), .SYNC_STAGES(2)) dut16 (
    .clock(clock), .reset(reset), .bus(bus16),
    .pad_in(pad_in16), .pad_out(pad_out16), .pad_oe(pad_oe16)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.cfg_in_base = '0;  bus.cfg_out_base = '0;  bus.cfg_set_base = '0;  bus.cfg_side_base = '0;
    bus.cfg_out_count = '0; bus.cfg_set_count = '0; bus.cfg_side_count = '0;
    bus.out_data = '0;  bus.out_en = 1'b0;  bus.out_dir = 1'b0;
    bus.set_data = '0;  bus.set_en = 1'b0;  bus.set_dir = 1'b0;
    bus.side_data = '0; bus.side_en = 1'b0; bus.side_dir = 1'b0;
    bus16.cfg_in_base = '0;  bus16.cfg_out_base = '0;  bus16.cfg_set_base = '0;  bus16.cfg_side_base = '0;
    bus16.cfg_out_count = '0; bus16.cfg_set_count = '0; bus16.cfg_side_count = '0;
    bus16.out_data = '0;  bus16.out_en = 1'b0;  bus16.out_dir = 1'b0;
    bus16.set_data = '0;  bus16.set_en = 1'b0;  bus16.set_dir = 1'b0;
    bus16.side_data = '0; bus16.side_en = 1'b0; bus16.side_dir = 1'b0;
  endtask

  task automatic outWr(input logic [4:0] base, input logic [5:0] cnt, input logic [31:0] data);
    idle();
    bus.cfg_out_base = base; bus.cfg_out_count = cnt; bus.out_data = data; bus.out_en = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    reset    = 1'b1;
    pad_in   = 32'hFFFF_FFFF;
    pad_in16 = 16'hFFFF;
    idle();
    repeat (3) tick();
    chk("rst_pad_out", pad_out, 32'h0);
    chk("rst_pad_oe", pad_oe, 32'h0);
    chk("rst_in_data", bus.in_data, 32'h0);
    chk("rst_in_data16", bus16.in_data, 32'h0);
    pad_in   = '0;
    pad_in16 = '0;
    repeat (3) tick();
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Full-width OUT write, then a wrapped window that must leave other bits alone.
    outWr(5'd0, 6'd32, 32'h1234_5678);
    chk("out_full", pad_out, 32'h1234_5678);
    chk("out_full_oe", pad_oe, 32'h0);

    bus.cfg_out_base = 5'd30; bus.cfg_out_count = 6'd4; bus.out_data = 32'hF; bus.out_en = 1'b1;
    #1;
    chk("out_wrap_before_edge", pad_out, 32'h1234_5678);
    tick();
    idle();
    chk("out_wrap_F", pad_out, 32'hD234_567B);

    outWr(5'd30, 6'd4, 32'h5);
    chk("out_wrap_5", pad_out, 32'h5234_5679);

    // side > SET > OUT on overlapping pins.
    idle();
    bus.cfg_out_count = 6'd8; bus.out_data = 32'h00; bus.out_en = 1'b1;
    bus.cfg_set_count = 3'd4; bus.set_data = 5'hF; bus.set_en = 1'b1;
    bus.cfg_side_base = 5'd2; bus.cfg_side_count = 3'd2; bus.side_data = 5'h0; bus.side_en = 1'b1;
    tick();
    idle();
    chk("priority", pad_out, 32'h5234_5603);

    // Side-set to pindirs and OUT to pins in the same cycle.
    bus.cfg_side_base = 5'd4; bus.cfg_side_count = 3'd1; bus.side_data = 5'h1;
    bus.side_dir = 1'b1; bus.side_en = 1'b1;
    bus.cfg_out_base = 5'd4; bus.cfg_out_count = 6'd1; bus.out_data = 32'h1; bus.out_en = 1'b1;
    tick();
    idle();
    chk("split_oe", pad_oe, 32'h0000_0010);
    chk("split_out", pad_out, 32'h5234_5613);

    // Count 0 on both registers: nothing changes.
    bus.out_data = 32'hFFFF_FFFF; bus.out_en = 1'b1;
    bus.set_data = 5'h1F; bus.set_dir = 1'b1; bus.set_en = 1'b1;
    tick();
    idle();
    chk("cnt0_out", pad_out, 32'h5234_5613);
    chk("cnt0_oe", pad_oe, 32'h0000_0010);

    // SET to pindirs across the wrap boundary.
    bus.cfg_set_base = 5'd30; bus.cfg_set_count = 3'd5; bus.set_data = 5'h1F;
    bus.set_dir = 1'b1; bus.set_en = 1'b1;
    tick();
    idle();
    chk("set_dir_wrap", pad_oe, 32'hC000_0017);
    chk("set_dir_wrap_out", pad_out, 32'h5234_5613);

    // Asynchronous reset between edges with enables active.
    bus.cfg_set_count = 3'd5; bus.set_data = 5'h1F; bus.set_en = 1'b1;
    bus.cfg_out_count = 6'd8; bus.out_data = 32'hFF; bus.out_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", pad_out, 32'h0);
    chk("async_rst_oe", pad_oe, 32'h0);
    tick();
    chk("rst_hold_out", pad_out, 32'h0);
    @(negedge clock);
    idle();
    bus.cfg_out_count = 6'd8; bus.out_data = 32'hA5; bus.out_en = 1'b1;
    reset = 1'b0;
    tick();
    idle();
    chk("first_wr_after_rst", pad_out, 32'h0000_00A5);

    // Input synchronizer latency and rotation.
    bus.cfg_in_base = 5'd8;
    pad_in = 32'h0000_0100;
    repeat (LAT - 1) tick();
    chk("in_lat_early", bus.in_data, 32'h0);
    tick();
    chk("in_lat", bus.in_data, 32'h1);
    pad_in = 32'h0000_0001;
    bus.cfg_in_base = 5'd4;
    repeat (3) tick();
    chk("in_rot_wrap", bus.in_data, 32'h1000_0000);

    // NPINS=16: count clamp, wrap at pin 15, base beyond NPINS, IN rotation.
    bus16.cfg_out_count = 6'd32; bus16.out_data = 32'hFFFF_ABCD; bus16.out_en = 1'b1;
    tick();
    idle();
    chk("n16_clamp", {16'h0, pad_out16}, 32'h0000_ABCD);
    bus16.cfg_out_base = 5'd14; bus16.cfg_out_count = 6'd4; bus16.out_data = 32'hF; bus16.out_en = 1'b1;
    tick();
    idle();
    chk("n16_wrap", {16'h0, pad_out16}, 32'h0000_EBCF);
    bus16.cfg_out_base = 5'd20; bus16.cfg_out_count = 6'd1; bus16.out_data = 32'h1; bus16.out_en = 1'b1;
    tick();
    idle();
    chk("n16_base_mod", {16'h0, pad_out16}, 32'h0000_EBDF);
    chk("n16_oe", {16'h0, pad_oe16}, 32'h0);
    pad_in16 = 16'h0001;
    bus16.cfg_in_base = 5'd4;
    repeat (3) tick();
    chk("n16_in_rot", bus16.in_data, 32'h0000_1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
